rv32i_core_top: RTL and testbench



---
 rtl/rv32i_core_top.sv | 177 +++++++++++++++++
 tb/tb_rv32i_core_top.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_core_top.sv
// rv32i_core_top: single-cycle RV32I integer core (no loads/stores/system).
// Fetch, decode, execute and writeback complete in one clk cycle.
// Optional macro CORE_TRACE_EN: prints a per-instruction trace line in simulation.

module rv32i_imem #(
    parameter int WORDS = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   data_o
);
    // Contents are preloaded from outside (hierarchically).
    logic [31:0] mem [0:WORDS-1];

    assign data_o = mem[addr_i];
endmodule

module rv32i_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_en_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o
);
    logic [31:0] registers [0:31];
    logic        write_en;

    assign write_en = write_en_i;

    // Synchronous clear on reset, otherwise single write port; x0 never written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (write_en && (rd_i != 5'd0)) begin
            registers[rd_i] <= wdata_i;
        end
    end

    assign rs1_data_o = (rs1_i == 5'd0) ? 32'd0 : registers[rs1_i];
    assign rs2_data_o = (rs2_i == 5'd0) ? 32'd0 : registers[rs2_i];
endmodule

module rv32i_core_top #(
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic reset
);
    localparam int AW = $clog2(IMEM_WORDS);

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    logic [31:0] pc, pc_d, pc_plus4;
    logic [31:0] instr, rs1_data, rs2_data, result;
    logic [4:0]  rd;
    logic        write_en;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_u, imm_b, imm_j;
    logic [31:0] alu_b, alu_out, sra_res;
    logic [4:0]  shamt;
    logic        br_taken;

    rv32i_imem #(.WORDS(IMEM_WORDS), .AW(AW)) i_mem (
        .addr_i (pc[AW+1:2]),
        .data_o (instr)
    );

    rv32i_regfile reg_file (
        .clk        (clk),
        .reset      (reset),
        .write_en_i (write_en),
        .rd_i       (rd),
        .wdata_i    (result),
        .rs1_i      (instr[19:15]),
        .rs2_i      (instr[24:20]),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data)
    );

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_u    = {instr[31:12], 12'b0};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;

    assign alu_b   = (opcode == OPC_OP) ? rs2_data : imm_i;
    assign shamt   = alu_b[4:0];
    // Kept in its own assignment so the arithmetic shift is not demoted to logical.
    assign sra_res = $unsigned($signed(rs1_data) >>> shamt);

    // ALU shared by OP and OP-IMM; instr[30] only means SUB for register-register ops.
    always_comb begin
        alu_out = '0;
        case (funct3)
            3'd0: alu_out = ((opcode == OPC_OP) && instr[30]) ? rs1_data - alu_b : rs1_data + alu_b;
            3'd1: alu_out = rs1_data << shamt;
            3'd2: alu_out = {31'b0, $signed(rs1_data) < $signed(alu_b)};
            3'd3: alu_out = {31'b0, rs1_data < alu_b};
            3'd4: alu_out = rs1_data ^ alu_b;
            3'd5: alu_out = instr[30] ? sra_res : (rs1_data >> shamt);
            3'd6: alu_out = rs1_data | alu_b;
            default: alu_out = rs1_data & alu_b;
        endcase
    end

    // Branch condition; the reserved funct3 codes 2/3 never branch.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'd0: br_taken = (rs1_data == rs2_data);
            3'd1: br_taken = (rs1_data != rs2_data);
            3'd4: br_taken = ($signed(rs1_data) < $signed(rs2_data));
            3'd5: br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'd6: br_taken = (rs1_data < rs2_data);
            3'd7: br_taken = (rs1_data >= rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    // Writeback value, write enable and next-PC selection per opcode.
    always_comb begin
        result   = '0;
        write_en = 1'b0;
        pc_d     = pc_plus4;
        case (opcode)
            OPC_LUI:   begin result = imm_u;      write_en = 1'b1; end
            OPC_AUIPC: begin result = pc + imm_u; write_en = 1'b1; end
            OPC_JAL: begin
                result   = pc_plus4;
                write_en = 1'b1;
                pc_d     = pc + imm_j;
            end
            OPC_JALR: begin
                result   = pc_plus4;
                write_en = 1'b1;
                pc_d     = (rs1_data + imm_i) & ~32'd1;
            end
            OPC_BRANCH: if (br_taken) pc_d = pc + imm_b;
            OPC_OPIMM, OPC_OP: begin result = alu_out; write_en = 1'b1; end
            default: ;
        endcase
    end

    // Program counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) pc <= RESET_PC;
        else        pc <= pc_d;
    end

`ifdef CORE_TRACE_EN
    // Simulation trace of every retired instruction.
    always @(posedge clk) begin
        if (reset) begin
            $display("PC: 0x%08h | Instr: 0x%08h | rd=%0d wr=%0d result=%0d",
                     pc, instr, rd, write_en, result);
            if (write_en && (rd != 5'd0)) $display("x%0d = %0d", rd, result);
        end
    end
`else
`endif
endmodule

// File: tb/tb_rv32i_core_top.sv
// Directed bench for rv32i_core_top: programs are poked into i_mem, results
// are compared against a scoreboard of expected values.

module tb_rv32i_core_top;
    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    rv32i_core_top #(.IMEM_WORDS(64), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] prog[$];

    localparam logic [31:0] PARK_FILL = 32'h0000_006f;

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] opi(int f3, int rd, int rs1, int imm);
        return enc_i(imm, rs1, f3, rd, 'h13);
    endfunction

    function automatic logic [31:0] opr(int f7, int f3, int rd, int rs1, int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        return {20'(imm20), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] br(int f3, int rs1, int rs2, int off);
        logic [31:0] m;
        m = off;
        return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
    endfunction

    function automatic logic [31:0] jal(int rd, int off);
        logic [31:0] m;
        m = off;
        return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6f};
    endfunction

    function automatic logic [31:0] xreg(int n);
        return dut.reg_file.registers[n];
    endfunction

    function automatic logic [31:0] nonzero_regs();
        int n = 0;
        for (int k = 1; k < 32; k++) if (dut.reg_file.registers[k] !== 32'd0) n++;
        return 32'(n);
    endfunction

    task automatic load();
        for (int i = 0; i < 64; i++) dut.i_mem.mem[i] = PARK_FILL;
        foreach (prog[i]) dut.i_mem.mem[i] = prog[i];
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic expect_val(string tag, logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(logic [31:0] obs);
        logic [31:0] e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic wait_pc(logic [31:0] target, int max);
        for (int c = 0; c < max; c++) begin
            if (dut.pc === target) break;
            @(negedge clk);
        end
    endtask

    task automatic sum_prog();
        prog.delete();
        prog.push_back(opi(0, 1, 0, 5));
        prog.push_back(opi(0, 2, 0, 0));
        prog.push_back(opr(0, 0, 2, 2, 1));
        prog.push_back(opi(0, 1, 1, -1));
        prog.push_back(br(1, 1, 0, -8));
        prog.push_back(opi(0, 0, 0, 0));
        prog.push_back(br(0, 0, 0, 0));
    endtask

    task automatic br_group(int rd, int f3_t, int rs1_t, int rs2_t, int f3_n, int rs1_n, int rs2_n);
        prog.push_back(opi(0, rd, 0, 1));
        prog.push_back(br(f3_t, rs1_t, rs2_t, 8));
        prog.push_back(opi(0, rd, 0, 0));
        prog.push_back(br(f3_n, rs1_n, rs2_n, 8));
        prog.push_back(jal(0, 8));
        prog.push_back(opi(0, rd, 0, 0));
    endtask

    initial begin
        int p;
        logic [31:0] park;

        // ---------------- reset state + sum loop ----------------
        sum_prog();
        load();
        do_reset();
        expect_val("reset_pc", 32'h0);
        check(dut.pc);
        expect_val("reset_regs_nonzero", 32'd0);
        check(nonzero_regs());

        wait_pc(32'h18, 50);
        expect_val("sum_pc_park", 32'h18);
        check(dut.pc);
        expect_val("sum_x1", 32'd0);
        check(xreg(1));
        expect_val("sum_x2", 32'd15);
        check(xreg(2));
        repeat (3) @(negedge clk);
        expect_val("sum_pc_hold", 32'h18);
        check(dut.pc);

        // ---------------- reset mid-run ----------------
        do_reset();
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_val("midreset_pc", 32'h0);
        check(dut.pc);
        expect_val("midreset_regs_nonzero", 32'd0);
        check(nonzero_regs());
        reset = 1'b1;
        wait_pc(32'h18, 50);
        expect_val("rerun_x2", 32'd15);
        check(xreg(2));
        expect_val("rerun_x1", 32'd0);
        check(xreg(1));

        // ---------------- ALU / branch / jump coverage ----------------
        prog.delete();
        prog.push_back(opi(0, 1, 0, -1));
        prog.push_back(opi(0, 2, 0, 1));
        prog.push_back(enc_u('h80000, 3, 'h37));
        prog.push_back(opi(0, 4, 0, 2));
        prog.push_back(opr(0, 2, 5, 1, 2));
        prog.push_back(opr(0, 3, 6, 1, 2));
        prog.push_back(opi(4, 6, 6, 1));
        prog.push_back(opi(2, 7, 1, 1));
        prog.push_back(opi(3, 8, 2, -1));
        prog.push_back(opi(5, 9, 3, 'h400 | 31));
        prog.push_back(opr(0, 0, 9, 9, 4));
        prog.push_back(opi(0, 10, 0, 31));
        prog.push_back(opr('h20, 5, 10, 3, 10));
        prog.push_back(opr('h20, 0, 10, 0, 10));
        prog.push_back(opi(5, 11, 3, 31));
        prog.push_back(opi(0, 12, 0, 31));
        prog.push_back(opr(0, 5, 12, 3, 12));
        prog.push_back(opi(1, 13, 2, 31));
        prog.push_back(opi(5, 13, 13, 31));
        prog.push_back(opi(0, 14, 0, 33));
        prog.push_back(opr(0, 1, 14, 2, 14));
        prog.push_back(opi(5, 14, 14, 1));
        prog.push_back(opr(0, 0, 15, 1, 4));
        prog.push_back(opr('h20, 0, 16, 4, 2));
        prog.push_back(opi(0, 17, 0, -2));
        prog.push_back(opr(0, 4, 17, 17, 1));
        prog.push_back(opr(0, 6, 18, 0, 2));
        prog.push_back(opr(0, 7, 19, 1, 2));
        prog.push_back(opi(7, 20, 1, 1));
        prog.push_back(opi(6, 21, 0, 1));
        prog.push_back(opi(4, 22, 4, 3));
        prog.push_back(opi(0, 23, 4, -1));
        prog.push_back(enc_u(1, 24, 'h37));
        prog.push_back(opi(5, 24, 24, 12));
        p = prog.size() * 4;
        prog.push_back(enc_u(0, 25, 'h17));
        prog.push_back(opi(0, 25, 25, 1 - p));
        prog.push_back(opi(0, 26, 0, 1));
        prog.push_back(jal(0, 8));
        prog.push_back(opi(0, 26, 0, 0));
        prog.push_back(enc_u(0, 27, 'h17));
        prog.push_back(enc_i(17, 27, 0, 0, 'h67));
        prog.push_back(opi(0, 27, 0, 0));
        prog.push_back(jal(0, 8));
        prog.push_back(opi(0, 27, 0, 1));
        br_group(28, 0, 2, 2, 1, 2, 2);
        br_group(29, 4, 1, 2, 5, 1, 2);
        br_group(30, 6, 2, 1, 7, 2, 1);
        park = 32'(prog.size() * 4);
        prog.push_back(br(0, 0, 0, 0));
        load();
        do_reset();
        wait_pc(park, 80);
        expect_val("alu_pc_park", park);
        check(dut.pc);
        for (int r = 5; r <= 30; r++) begin
            expect_val($sformatf("alu_x%0d", r), 32'd1);
            check(xreg(r));
        end

        // ---------------- x0 protection ----------------
        prog.delete();
        prog.push_back(opi(0, 0, 0, 7));
        prog.push_back(opr(0, 0, 3, 0, 0));
        prog.push_back(br(0, 0, 0, 0));
        load();
        do_reset();
        repeat (3) @(negedge clk);
        expect_val("x0_reg", 32'd0);
        check(xreg(0));
        expect_val("x0_x3", 32'd0);
        check(xreg(3));
        expect_val("x0_rs1_read", 32'd0);
        check(dut.rs1_data);

        // ---------------- jumps ----------------
        prog.delete();
        prog.push_back(jal(1, 8));
        prog.push_back(opi(0, 1, 0, 'h7ff));
        prog.push_back(opi(0, 1, 0, 'h10));
        prog.push_back(enc_i(3, 1, 0, 5, 'h67));
        prog.push_back(br(0, 0, 0, 0));
        load();
        do_reset();
        @(negedge clk);
        expect_val("jal_pc", 32'h8);
        check(dut.pc);
        expect_val("jal_link", 32'h4);
        check(xreg(1));
        repeat (2) @(negedge clk);
        expect_val("jalr_pc", 32'h12);
        check(dut.pc);
        expect_val("jalr_link", 32'h10);
        check(xreg(5));
        repeat (3) @(negedge clk);
        expect_val("jalr_park_hold", 32'h12);
        check(dut.pc);

        // ---------------- unimplemented opcodes ----------------
        prog.delete();
        prog.push_back(enc_i(0, 0, 2, 4, 'h03));
        prog.push_back(32'h0000_0073);
        prog.push_back(32'h0000_2023);
        prog.push_back(br(0, 0, 0, 0));
        load();
        do_reset();
        @(negedge clk);
        expect_val("lw_pc", 32'h4);
        check(dut.pc);
        expect_val("lw_x4", 32'd0);
        check(xreg(4));
        repeat (2) @(negedge clk);
        expect_val("sys_store_pc", 32'hc);
        check(dut.pc);
        expect_val("unimpl_regs_nonzero", 32'd0);
        check(nonzero_regs());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
